fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Write-side arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters in the wr_clk domain.
- Round-robin selection with bounded bursts per grant.
- Throttles on the FIFO's full/almost_full flags so the FIFO never sees a write while full.
- Drives registered wr_en/wr_data straight into the FIFO write port.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- NREQ, 4, number of requesters; minimum 2.
- MAX_BURST, 4, maximum words accepted per grant; minimum 1.
- IDW, $clog2(NREQ), width of the owner index.

Ports:
- wr_clk  input  1  write-domain clock; all logic on posedge.
- rstn  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request; held high while the requester has a word.
- req_data  input  NREQ*WIDTH  requester i's word occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  combinational one-hot accept strobe; the word is consumed at this edge.
- wr_en  output  1  registered FIFO write enable.
- wr_data  output  WIDTH  registered FIFO write data.
- full  input  1  FIFO full flag.
- almost_full  input  1  FIFO almost_full flag.
- overflow  input  1  FIFO overflow flag.
- clr_err  input  1  clears ovf_err.
- busy  output  1  high in BURST or STALL.
- owner  output  IDW  current grant holder; valid while busy.
- ovf_err  output  1  sticky error, set on any overflow.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; gnt=0, wr_en=0, wr_data=0, busy=0, owner=0, ovf_err=0.
  - rr_ptr=0, burst_cnt=0.
  - Takes effect immediately, including mid-burst. Any word not yet strobed by gnt is not consumed.
- space_ok = !full && !(wr_en && almost_full). This reserves room for the write already in flight, because full lags that write by one edge.
- States: IDLE, BURST, STALL.
- IDLE:
  - If any req bit is high, owner <= first set bit searching from rr_ptr upward, with wrap.
  - burst_cnt<=0; next state BURST.
  - gnt=0 in IDLE, so arbitration costs one cycle.
- BURST: accept = req[owner] && space_ok && burst_cnt<MAX_BURST.
  - On accept: gnt[owner]=1; next edge wr_en<=1, wr_data<=req_data[owner], burst_cnt++.
  - If accept is low, wr_en<=0.
  - Go to IDLE with rr_ptr<=owner+1 (mod NREQ) when either:
    - req[owner]=0, or
    - an accept makes burst_cnt equal MAX_BURST.
  - Otherwise, if req[owner]=1 and space_ok=0: go to STALL.
- STALL:
  - gnt=0, wr_en<=0.
  - space_ok=1 -> BURST, burst_cnt retained.
  - req[owner]=0 -> IDLE, rr_ptr<=owner+1.
- Latency: a gnt in cycle N gives wr_en=1 and the word on wr_data in cycle N+1. One write is issued per accepted word, never duplicated.
- Requester rule: req_data must be stable while req is high. Dropping req is allowed at any cycle.
- Fairness: after releasing, an owner is not eligible again before every other active requester has been granted once.
- ovf_err:
  - Set on any wr_clk edge where overflow=1.
  - Cleared by clr_err=1 only when overflow=0; set wins over clear.
- Invariant: the arbiter never drives wr_en=1 in a cycle where full=1 was sampled at the issuing edge.

Test Plan:
- Requester 0 alone, 3 words A1,A2,A3, FIFO empty, MAX_BURST=4:
  - gnt[0] in 3 consecutive cycles after one IDLE cycle.
  - wr_en high 3 cycles, data in order; then IDLE with rr_ptr=1.
- All 4 requesters hold req with 8 words each:
  - Grant order 0,1,2,3,0,1,2,3.
  - Each grant is exactly 4 writes followed by 1 idle cycle.
  - 32 writes total, no data reordering within a requester.
- FIFO DEPTH 16 with the read side stalled, requester 2 streaming:
  - Writes stop with wr_en=0 once full/almost_full blocks; state STALL, busy=1, owner=2.
  - Exactly 16 words written; overflow never asserts.
  - After 3 reads, BURST resumes and exactly 3 more words are written.
- rstn pulsed low mid-burst, after 2 of 4 words:
  - gnt, wr_en, busy, owner, ovf_err are 0 immediately.
  - After release, a new arbitration starts from requester 0.
- Force overflow=1 for 1 cycle:
  - ovf_err=1 and it stays high.
  - clr_err with overflow=0 clears it; clr_err together with overflow=1 keeps it at 1.
- Requester 1 drops req after 1 word while requester 3 waits:
  - Requester 1 releases after 1 write.
  - Next owner is 3; rr_ptr advances to 0 after requester 3 releases.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO: bounded bursts per grant,
// throttled on full/almost_full, registered wr_en/wr_data into the FIFO.
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned IDW       = $clog2(NREQ)
) (
    input  logic                  wr_clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  wr_en,
    output logic [WIDTH-1:0]      wr_data,
    input  logic                  full,
    input  logic                  almost_full,
    input  logic                  overflow,
    input  logic                  clr_err,
    output logic                  busy,
    output logic [IDW-1:0]        owner,
    output logic                  ovf_err
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {StIdle, StBurst, StStall} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic              ovf_err_q, ovf_err_d;

    logic [WIDTH-1:0]  req_words [NREQ];
    logic [IDW-1:0]    pick;
    logic [IDW-1:0]    owner_inc;
    logic              space_ok;
    logic              owner_req;
    logic              last_word;
    logic              accept;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_words[i] = req_data[i*WIDTH +: WIDTH];
    end

    // First requesting index at or above rr_ptr, wrapping around.
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] cand;
        logic           found;
        pick  = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx  = (int'(rr_ptr_q) + k) % NREQ;
            cand = IDW'(idx);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // full lags an in-flight write by one edge, so reserve a slot for it.
    assign space_ok  = !full && !(wr_en_q && almost_full);
    assign owner_req = req[owner_q];
    assign last_word = (burst_cnt_q == CntW'(MAX_BURST - 1));
    assign owner_inc = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);
    assign accept    = (state_q == StBurst) && owner_req && space_ok &&
                       (burst_cnt_q < CntW'(MAX_BURST));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        gnt         = '0;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    owner_d     = pick;
                    burst_cnt_d = '0;
                    state_d     = StBurst;
                end
            end
            StBurst: begin
                if (accept) begin
                    gnt[owner_q] = 1'b1;
                    wr_en_d      = 1'b1;
                    wr_data_d    = req_words[owner_q];
                    burst_cnt_d  = burst_cnt_q + CntW'(1);
                end
                if (!owner_req || (accept && last_word)) begin
                    state_d  = StIdle;
                    rr_ptr_d = owner_inc;
                end else if (!space_ok) begin
                    state_d = StStall;
                end
            end
            StStall: begin
                if (!owner_req) begin
                    state_d  = StIdle;
                    rr_ptr_d = owner_inc;
                end else if (space_ok) begin
                    state_d = StBurst;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Set wins over clear.
    assign ovf_err_d = overflow | (ovf_err_q & ~clr_err);

    always_ff @(posedge wr_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != StIdle);
    assign owner   = owner_q;
    assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requester queues, a FIFO occupancy model and a
// write scoreboard drive directed and random scenarios.
module tb_fifo_wr_arbiter;

    localparam int WIDTH     = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;
    localparam int IDW       = 2;

    logic                  wr_clk = 1'b0;
    logic                  rstn;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  wr_en;
    logic [WIDTH-1:0]      wr_data;
    logic                  full, almost_full, overflow, clr_err;
    logic                  busy;
    logic [IDW-1:0]        owner;
    logic                  ovf_err;

    fifo_wr_arbiter #(
        .WIDTH    (WIDTH),
        .NREQ     (NREQ),
        .MAX_BURST(MAX_BURST),
        .IDW      (IDW)
    ) dut (
        .wr_clk     (wr_clk),
        .rstn       (rstn),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .almost_full(almost_full),
        .overflow   (overflow),
        .clr_err    (clr_err),
        .busy       (busy),
        .owner      (owner),
        .ovf_err    (ovf_err)
    );

    always #5 wr_clk = ~wr_clk;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] wq [NREQ][$];
    logic [NREQ-1:0]  req_en;
    int  fcnt, fdepth, rd_pending;
    bit  drain, ovf_pend, force_ovf, clr_cmd;
    bit  exp_wv, exp_ovf, prev_busy, arb_pending, exp_idle;
    logic [WIDTH-1:0] exp_wd;
    int  ptr_m, last_owner, bcnt, arb_exp, writes;
    int  burst_log[$];
    int  wr_by[NREQ];

    logic [NREQ-1:0]  s_gnt;
    logic             s_wr_en, s_busy, s_ovf;
    logic [IDW-1:0]   s_owner;
    logic [WIDTH-1:0] s_wr_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_m(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit qs_nonempty();
        for (int i = 0; i < NREQ; i++) if (wq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive at negedge, sample 1ns later, check, advance the models.
    task automatic cycle();
        int  old_cnt;
        bit  rd;
        @(negedge wr_clk);
        for (int i = 0; i < NREQ; i++) begin
            req[i] = req_en[i] && (wq[i].size() > 0);
            req_data[i*WIDTH +: WIDTH] = (wq[i].size() > 0) ? wq[i][0] : '0;
        end
        full        = (fcnt >= fdepth);
        almost_full = (fcnt >= fdepth - 1);
        overflow    = ovf_pend || force_ovf;
        clr_err     = clr_cmd;
        #1;
        s_gnt = gnt; s_wr_en = wr_en; s_wr_data = wr_data;
        s_busy = busy; s_owner = owner; s_ovf = ovf_err;

        chk("wr_en", 32'(s_wr_en), 32'(exp_wv));
        if (exp_wv) chk("wr_data", 32'(s_wr_data), 32'(exp_wd));
        chk("ovf_err", 32'(s_ovf), 32'(exp_ovf));
        if (exp_idle) chk("release", 32'(s_busy), 0);
        if (arb_pending) begin
            chk("arb_busy", 32'(s_busy), 1);
            chk("arb_owner", 32'(s_owner), 32'(arb_exp));
            burst_log.push_back(int'(s_owner));
            bcnt = 0;
        end
        if (prev_busy && !s_busy) ptr_m = (last_owner + 1) % NREQ;
        exp_idle    = 1'b0;
        arb_pending = 1'b0;
        if (!s_busy) begin
            chk("idle_gnt", 32'(s_gnt), 0);
            if (req != '0) begin
                arb_pending = 1'b1;
                arb_exp     = pick_m(req, ptr_m);
            end
        end else begin
            last_owner = int'(s_owner);
            if (!req[s_owner]) exp_idle = 1'b1;
            chk("gnt_subset", 32'(s_gnt & ~req), 0);
            if (s_gnt != '0) begin
                chk("gnt_onehot", 32'(s_gnt), 32'(1) << s_owner);
                chk("gnt_full", 32'(full), 0);
                bcnt++;
                chk("burst_len", 32'(bcnt <= MAX_BURST), 1);
                if (bcnt >= MAX_BURST) exp_idle = 1'b1;
            end
        end
        prev_busy = s_busy;

        exp_wv = (s_gnt != '0);
        for (int i = 0; i < NREQ; i++) begin
            if (s_gnt[i] && wq[i].size() > 0) begin
                exp_wd = wq[i].pop_front();
                wr_by[i]++;
            end
        end
        old_cnt  = fcnt;
        ovf_pend = s_wr_en && (old_cnt >= fdepth);
        if (s_wr_en) begin
            writes++;
            chk("no_overflow", 32'(ovf_pend), 0);
        end
        rd = (drain || rd_pending > 0) && old_cnt > 0;
        if (rd && rd_pending > 0) rd_pending--;
        fcnt = old_cnt + ((s_wr_en && old_cnt < fdepth) ? 1 : 0) - (rd ? 1 : 0);
        exp_ovf = overflow ? 1'b1 : (clr_err ? 1'b0 : exp_ovf);
    endtask

    // Reset lands just after an edge, so words granted before it are consumed.
    task automatic do_reset();
        @(posedge wr_clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_ovf_err", 32'(ovf_err), 0);
        exp_wv = 0; exp_ovf = 0; ptr_m = 0; prev_busy = 0;
        arb_pending = 0; exp_idle = 0; bcnt = 0; ovf_pend = 0;
        @(posedge wr_clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic run_until_idle(input int limit);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((qs_nonempty() || s_busy || s_wr_en) && n < limit);
        chk("drain_done", 32'(qs_nonempty() || s_busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] g1 [6];
        logic            w1 [6];
        int eg1 [6] = '{0, 1, 1, 1, 0, 0};
        int ew1 [6] = '{0, 0, 1, 1, 1, 0};
        int n, ng, pushed, w_start;

        req = '0; req_data = '0; full = 0; almost_full = 0; overflow = 0; clr_err = 0;
        req_en = '1; fdepth = 16; drain = 1; fcnt = 0; rd_pending = 0;
        ovf_pend = 0; force_ovf = 0; clr_cmd = 0;
        exp_wv = 0; exp_wd = '0; exp_ovf = 0; ptr_m = 0; last_owner = 0; bcnt = 0;
        prev_busy = 0; arb_pending = 0; exp_idle = 0; arb_exp = 0; writes = 0;
        for (int i = 0; i < NREQ; i++) wr_by[i] = 0;

        rstn = 1'b0;
        #3;
        chk("por_busy", 32'(busy), 0);
        chk("por_wr_en", 32'(wr_en), 0);
        chk("por_ovf_err", 32'(ovf_err), 0);
        @(posedge wr_clk);
        #1;
        rstn = 1'b1;

        // Requester 0 alone, three words.
        wq[0].push_back(8'hA1); wq[0].push_back(8'hA2); wq[0].push_back(8'hA3);
        for (int k = 0; k < 6; k++) begin
            cycle();
            g1[k] = s_gnt;
            w1[k] = s_wr_en;
        end
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t1_gnt[%0d]", k), 32'(g1[k]), 32'(eg1[k]));
            chk($sformatf("t1_wr_en[%0d]", k), 32'(w1[k]), 32'(ew1[k]));
        end
        chk("t1_idle", 32'(s_busy), 0);
        wq[0].push_back(8'h10); wq[1].push_back(8'h11);
        cycle(); cycle();
        chk("t1_rr_ptr", 32'(s_owner), 1);
        run_until_idle(50);

        // All four requesters, eight words each.
        do_reset();
        burst_log.delete();
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 8; j++) wq[i].push_back(8'((i << 4) | j));
        w_start = writes;
        for (int k = 0; k < 42; k++) begin
            cycle();
            if (k < 40)
                chk($sformatf("t2_gnt[%0d]", k), 32'(s_gnt),
                    (k % 5 == 0) ? 0 : (32'(1) << ((k / 5) % 4)));
        end
        chk("t2_writes", 32'(writes - w_start), 32);
        chk("t2_bursts", 32'(burst_log.size()), 8);
        for (int k = 0; k < burst_log.size() && k < 8; k++)
            chk($sformatf("t2_order[%0d]", k), 32'(burst_log[k]), 32'(k % 4));

        // FIFO depth 16 with the read side stalled.
        drain = 0; fcnt = 0;
        for (int j = 0; j < 40; j++) wq[2].push_back(8'(8'h80 + j));
        w_start = writes;
        repeat (40) cycle();
        chk("t3_writes", 32'(writes - w_start), 16);
        chk("t3_fcnt", 32'(fcnt), 16);
        chk("t3_busy", 32'(s_busy), 1);
        chk("t3_owner", 32'(s_owner), 2);
        chk("t3_wr_en", 32'(s_wr_en), 0);
        chk("t3_gnt", 32'(s_gnt), 0);
        rd_pending = 3;
        w_start = writes;
        repeat (20) cycle();
        chk("t3_resume_writes", 32'(writes - w_start), 3);
        chk("t3_resume_fcnt", 32'(fcnt), 16);
        chk("t3_restall_owner", 32'(s_owner), 2);
        drain = 1;
        run_until_idle(300);

        // Reset mid-burst after two words of requester 2.
        req_en[0] = 1'b0;
        for (int j = 0; j < 6; j++) wq[0].push_back(8'(8'hC0 + j));
        for (int j = 0; j < 4; j++) wq[2].push_back(8'(8'hD0 + j));
        ng = 0; n = 0;
        while (ng < 2 && n < 20) begin
            cycle();
            if (s_gnt[2]) ng++;
            n++;
        end
        chk("t4_two_grants", 32'(ng), 2);
        req_en[0] = 1'b1;
        do_reset();
        cycle(); cycle();
        chk("t4_owner_after_reset", 32'(s_owner), 0);
        chk("t4_busy_after_reset", 32'(s_busy), 1);
        run_until_idle(200);

        // Sticky overflow error.
        cycle();
        chk("t5_pre", 32'(s_ovf), 0);
        force_ovf = 1; cycle(); force_ovf = 0; cycle();
        chk("t5_set", 32'(s_ovf), 1);
        repeat (3) cycle();
        chk("t5_sticky", 32'(s_ovf), 1);
        force_ovf = 1; clr_cmd = 1; cycle(); force_ovf = 0; clr_cmd = 0; cycle();
        chk("t5_set_wins", 32'(s_ovf), 1);
        clr_cmd = 1; cycle(); clr_cmd = 0; cycle();
        chk("t5_cleared", 32'(s_ovf), 0);

        // Requester 1 drops after one word while requester 3 waits.
        do_reset();
        burst_log.delete();
        for (int i = 0; i < NREQ; i++) wr_by[i] = 0;
        wq[1].push_back(8'h61); wq[1].push_back(8'h62);
        for (int j = 0; j < 3; j++) wq[3].push_back(8'(8'h70 + j));
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_gnt[1] && n < 10);
        req_en[1] = 1'b0;
        repeat (12) cycle();
        chk("t6_req1_writes", 32'(wr_by[1]), 1);
        chk("t6_req3_writes", 32'(wr_by[3]), 3);
        chk("t6_bursts", 32'(burst_log.size()), 2);
        if (burst_log.size() >= 2) begin
            chk("t6_first", 32'(burst_log[0]), 1);
            chk("t6_second", 32'(burst_log[1]), 3);
        end
        req_en[1] = 1'b1;
        for (int i = 0; i < NREQ; i++) wq[i].push_back(8'(8'hE0 + i));
        cycle(); cycle();
        chk("t6_ptr_wrapped", 32'(s_owner), 0);
        run_until_idle(200);

        // Random traffic, drops, FIFO back-pressure and error clears.
        pushed = 0;
        w_start = writes;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                n = $urandom_range(0, NREQ - 1);
                if (wq[n].size() < 10) begin
                    wq[n].push_back(8'($urandom));
                    pushed++;
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                n = $urandom_range(0, NREQ - 1);
                req_en[n] = ~req_en[n];
            end
            drain   = ($urandom_range(0, 2) == 0);
            clr_cmd = ($urandom_range(0, 31) == 0);
            cycle();
        end
        req_en = '1; drain = 1; clr_cmd = 0;
        run_until_idle(500);
        chk("t7_all_written", 32'(writes - w_start), 32'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
